// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding and default constants
// shared by the reset sequencer files.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_DOMAINS  = 4;
  localparam int DEF_INIT_HOLD    = 15;
  localparam int DEF_STAGE_GAP    = 4;
  localparam int DEF_LOAD_TIMEOUT = 1 << 24;

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: loader handshake and reset fan-out
// bundle; master drives load/soft requests, slave is the sequencer.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS
);

  logic                   load_done;
  logic                   soft_reset_req;
  logic                   loader_reset;
  logic [NUM_DOMAINS-1:0] domain_reset;
  logic [1:0]             seq_state;
  logic                   load_timeout;

  modport master (
    output load_done,
    output soft_reset_req,
    input  loader_reset,
    input  domain_reset,
    input  seq_state,
    input  load_timeout
  );

  modport slave (
    input  load_done,
    input  soft_reset_req,
    output loader_reset,
    output domain_reset,
    output seq_state,
    output load_timeout
  );

endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: HOLD -> LOAD -> RELEASE -> RUN staged reset release.
// Define RESET_SEQ_TIMEOUT_EN to enable the LOAD-phase watchdog.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
  parameter int INIT_HOLD    = DEF_INIT_HOLD,
  parameter int STAGE_GAP    = DEF_STAGE_GAP,
  parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   chip_reset,
  input  logic                   load_done,
  input  logic                   soft_reset_req,
  output logic                   loader_reset,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic [1:0]             seq_state,
  output logic                   load_timeout
);

  localparam int IW = $clog2(NUM_DOMAINS);

  localparam logic [15:0]   HOLD_INIT = 16'(INIT_HOLD);
  localparam logic [7:0]    GAP       = 8'(STAGE_GAP);
  localparam logic [IW-1:0] LAST      = IW'(NUM_DOMAINS - 1);

  localparam logic [NUM_DOMAINS-1:0] ALL_ON  = '1;
  localparam logic [NUM_DOMAINS-1:0] LOAD_ON = ALL_ON << 1;

  seq_state_t             state_q = HOLD;
  seq_state_t             state_d;
  logic [15:0]            hold_q  = HOLD_INIT;
  logic [15:0]            hold_d;
  logic [7:0]             stage_q = GAP;
  logic [7:0]             stage_d;
  logic [IW-1:0]          idx_q   = IW'(1);
  logic [IW-1:0]          idx_d;
  logic                   lrst_q  = 1'b1;
  logic                   lrst_d;
  logic [NUM_DOMAINS-1:0] drst_q  = ALL_ON;
  logic [NUM_DOMAINS-1:0] drst_d;

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(LOAD_TIMEOUT - 1);

  logic [31:0] wd_q   = '0;
  logic [31:0] wd_d;
  logic        tout_q = 1'b0;
  logic        tout_d;
`else
  logic unused_timeout;
  assign unused_timeout = |32'(LOAD_TIMEOUT);
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    lrst_d  = lrst_q;
    drst_d  = drst_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    tout_d  = tout_q;
`endif

    if (chip_reset) begin
      state_d = HOLD;
      hold_d  = HOLD_INIT;
      stage_d = GAP;
      idx_d   = IW'(1);
      lrst_d  = 1'b1;
      drst_d  = ALL_ON;
`ifdef RESET_SEQ_TIMEOUT_EN
      tout_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        HOLD: begin
          lrst_d = 1'b1;
          drst_d = ALL_ON;
          if (hold_q <= 16'd1) begin
            state_d = LOAD;
            hold_d  = '0;
            lrst_d  = 1'b0;
            drst_d  = LOAD_ON;
          end else begin
            hold_d = hold_q - 16'd1;
          end
        end

        LOAD: begin
          if (load_done) begin
            drst_d[1] = 1'b0;
            stage_d   = GAP;
            if (NUM_DOMAINS == 2) begin
              state_d = RUN;
            end else begin
              state_d = RELEASE;
              idx_d   = IW'(2);
            end
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (wd_q >= WD_LAST) begin
            state_d = HOLD;
            hold_d  = HOLD_INIT;
            lrst_d  = 1'b1;
            drst_d  = ALL_ON;
            tout_d  = 1'b1;
          end
`endif
        end

        RELEASE: begin
          if (stage_q <= 8'd1) begin
            drst_d[idx_q] = 1'b0;
            stage_d       = GAP;
            if (idx_q == LAST) begin
              state_d = RUN;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            stage_d = stage_q - 8'd1;
          end
        end

        RUN: begin
          lrst_d = 1'b0;
          drst_d = '0;
        end

        default: state_d = HOLD;
      endcase

      // Soft restart re-arms run domains; loader domain stays live.
      if (soft_reset_req &&
          (state_q == RELEASE || state_q == RUN)) begin
        state_d = RELEASE;
        stage_d = GAP;
        idx_d   = IW'(1);
        lrst_d  = 1'b0;
        drst_d  = LOAD_ON;
      end
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  always_comb begin
    wd_d = '0;
    if (!chip_reset && state_q == LOAD && state_d == LOAD) begin
      wd_d = (wd_q == '1) ? wd_q : wd_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    state_q <= state_d;
    hold_q  <= hold_d;
    stage_q <= stage_d;
    idx_q   <= idx_d;
    lrst_q  <= lrst_d;
    drst_q  <= drst_d;
`ifdef RESET_SEQ_TIMEOUT_EN
    wd_q    <= wd_d;
    tout_q  <= tout_d;
`endif
  end

  assign loader_reset = lrst_q;
  assign domain_reset = drst_q;
  assign seq_state    = state_q;

`ifdef RESET_SEQ_TIMEOUT_EN
  assign load_timeout = tout_q;
`else
  assign load_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: timestamp-based reference model feeding a
// scoreboard queue; a monitor compares every cycle's outputs.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int N   = 4;
  localparam int IH  = 15;
  localparam int GAP = 4;
  localparam int LT  = 100;

  logic clk = 1'b1;
  logic chip_reset = 1'b1;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_DOMAINS(N)) bus ();

  reset_sequencer #(
    .NUM_DOMAINS (N),
    .INIT_HOLD   (IH),
    .STAGE_GAP   (GAP),
    .LOAD_TIMEOUT(LT)
  ) dut (
    .clk           (clk),
    .chip_reset    (chip_reset),
    .load_done     (bus.load_done),
    .soft_reset_req(bus.soft_reset_req),
    .loader_reset  (bus.loader_reset),
    .domain_reset  (bus.domain_reset),
    .seq_state     (bus.seq_state),
    .load_timeout  (bus.load_timeout)
  );

  typedef struct packed {
    logic         lr;
    logic [N-1:0] dr;
    logic [1:0]   st;
    logic         to;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model: edge numbers of the last reset, of load_done acceptance,
  // and of the base edge from which run domains release.
  int e         = 0;
  int rst_edge  = 0;
  int done_edge = -1;
  int base      = 0;
  bit tout      = 1'b0;

  function automatic exp_t predict();
    exp_t x;
    x.to = tout;
    if (e < rst_edge + IH) begin
      x.lr = 1'b1;
      x.dr = '1;
      x.st = 2'(HOLD);
    end else if (done_edge < 0) begin
      x.lr = 1'b0;
      x.dr = '1;
      x.dr[0] = 1'b0;
      x.st = 2'(LOAD);
    end else begin
      x.lr = 1'b0;
      x.dr = '0;
      for (int k = 1; k < N; k++)
        x.dr[k] = (e < base + (k - 1) * GAP);
      x.st = (e >= base + (N - 2) * GAP) ? 2'(RUN) : 2'(RELEASE);
    end
    return x;
  endfunction

  task automatic step(input bit cr, input bit ld, input bit sr);
    int load_edge;
    @(negedge clk);
    chip_reset         = cr;
    bus.load_done      = ld;
    bus.soft_reset_req = sr;
    e++;
    load_edge = rst_edge + IH;
    if (cr) begin
      rst_edge  = e;
      done_edge = -1;
      tout      = 1'b0;
    end else if (done_edge < 0 && e > load_edge) begin
      if (ld) begin
        done_edge = e;
        base      = e;
      end
`ifdef RESET_SEQ_TIMEOUT_EN
      else if (e - load_edge >= LT) begin
        rst_edge = e;
        tout     = 1'b1;
      end
`endif
    end else if (done_edge >= 0 && sr) begin
      base = e + GAP;
    end
    q.push_back(predict());
  endtask

  task automatic idle(input int n, input bit ld);
    for (int i = 0; i < n; i++) step(1'b0, ld, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got === want) begin
      passes++;
    end else begin
      fails++;
      $display("FAIL %s cyc %0d got %0h want %0h",
               name, cyc, got, want);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("loader_reset", 32'(bus.loader_reset), 32'(x.lr));
        chk("domain_reset", 32'(bus.domain_reset), 32'(x.dr));
        chk("seq_state",    32'(bus.seq_state),    32'(x.st));
        chk("load_timeout", 32'(bus.load_timeout), 32'(x.to));
      end
    end
  end

  initial begin : driver
    bit ld;
    int wait_cyc;
    bus.load_done      = 1'b0;
    bus.soft_reset_req = 1'b0;
    #1;
    chk("powerup_state",  32'(bus.seq_state),    32'(HOLD));
    chk("powerup_loader", 32'(bus.loader_reset), 32'd1);
    chk("powerup_domain", 32'(bus.domain_reset), 32'hF);
    chk("powerup_tout",   32'(bus.load_timeout), 32'd0);

    repeat (3) step(1'b1, 1'b0, 1'b0);
    idle(20, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(20, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(20, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(5, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(20, 1'b0);

    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(18, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    idle(20, 1'b1);
    idle(10, 1'b0);

    step(1'b1, 1'b0, 1'b0);
    idle(160, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(5, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(15, 1'b0);

    ld = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) ld = !ld;
      step($urandom_range(0, 299) == 0, ld,
           $urandom_range(0, 24) == 0);
    end
    idle(10, 1'b0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
